// File: rtl/seg_sniffer.sv
// seg_sniffer: recovers the digits shown on a multiplexed active-low 7-segment display by sniffing its lines.
// Optional macro SEG_SNIFFER_HEX_EN extends the decode table with hex digits A..F.
module seg_sniffer #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits,
  output logic [3:0]  seg_err,
  output logic        frame_valid
);
  typedef enum logic {SETTLE, HOLD} state_t;
  state_t state, state_nx;
  logic [6:0] seg_m, seg_s;
  logic [3:0] an_m, an_s;
  logic [10:0] prev;
  logic [7:0] cnt, cnt_nx;
  logic same, take, cap, bad;
  logic [1:0] slot;
  logic [3:0] val, stg_err, captured;
  logic [3:0] stg_val [4];
  assign same = {an_s, seg_s} == prev;
  assign cnt_nx = !same ? 8'd0 : (cnt == 8'hFF ? cnt : cnt + 8'd1);
  always_comb begin
    take = state == SETTLE && cnt_nx >= 8'(STABLE_CYCLES - 1);
    state_nx = take ? HOLD : (state == HOLD && !same) ? SETTLE : state;
  end
  assign cap = take && $onehot(~an_s);
  assign slot = !an_s[0] ? 2'd0 : !an_s[1] ? 2'd1 : !an_s[2] ? 2'd2 : 2'd3;
  always_comb begin
    {bad, val} = 5'h1F;
    case (seg_s)
      7'b0000001: {bad, val} = 5'h00;
      7'b1001111: {bad, val} = 5'h01;
      7'b0010010: {bad, val} = 5'h02;
      7'b0000110: {bad, val} = 5'h03;
      7'b1001100: {bad, val} = 5'h04;
      7'b0100100: {bad, val} = 5'h05;
      7'b0100000: {bad, val} = 5'h06;
      7'b0001111: {bad, val} = 5'h07;
      7'b0000000: {bad, val} = 5'h08;
      7'b0000100: {bad, val} = 5'h09;
`ifdef SEG_SNIFFER_HEX_EN
      7'b0001000: {bad, val} = 5'h0A;
      7'b1100000: {bad, val} = 5'h0B;
      7'b0110001: {bad, val} = 5'h0C;
      7'b1000010: {bad, val} = 5'h0D;
      7'b0110000: {bad, val} = 5'h0E;
      7'b0111000: {bad, val} = 5'h0F;
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {seg_m, seg_s, an_m, an_s, prev, cnt} <= '0;
      state <= SETTLE;
      stg_val <= '{default: '0};
      {stg_err, captured, digits, seg_err, frame_valid} <= '0;
    end else begin
      {seg_m, seg_s, an_m, an_s} <= {seg_in, seg_m, an_in, an_m};
      prev <= {an_s, seg_s};
      cnt <= cnt_nx;
      state <= state_nx;
      frame_valid <= &captured;
      if (&captured) begin
        digits <= {stg_val[3], stg_val[2], stg_val[1], stg_val[0]};
        seg_err <= stg_err;
      end
      // a capture landing on the clearing edge seeds the next frame
      captured <= (&captured ? 4'b0 : captured) | (cap ? 4'b1 << slot : 4'b0);
      if (cap) begin
        stg_val[slot] <= val;
        stg_err[slot] <= bad;
      end
    end
  end
endmodule

// File: tb/tb_seg_sniffer.sv
// tb_seg_sniffer: table-driven frames, hand-written corner sequences and random scans
// checked every cycle against a run-length reference model.
module tb_seg_sniffer;
  localparam int S = 4;
`ifdef SEG_SNIFFER_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif
  localparam logic [6:0] P [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
    7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] seg_in = '1;
  logic [3:0] an_in = '1;
  logic [15:0] digits;
  logic [3:0] seg_err;
  logic frame_valid;
  int ntot = 0, npass = 0, fv_cnt = 0;
  seg_sniffer #(.STABLE_CYCLES(S)) dut (.clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .digits(digits), .seg_err(seg_err), .frame_valid(frame_valid));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [4:0] mdec(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (s == P[i]) return {1'b0, 4'(i)};
    if (HEX) for (int i = 10; i < 16; i++) if (s == P[i]) return {1'b0, 4'(i)};
    return 5'h1F;
  endfunction

  // Reference: a pattern is taken once its input run reaches S samples; outputs
  // appear two edges later than the model because of the input synchroniser.
  logic armed = 1'b0;
  logic [10:0] m_last;
  int m_run;
  logic [3:0] m_val [4];
  logic [3:0] m_err, m_cap, m_serr;
  logic [15:0] m_dig;
  logic m_fv;
  logic [20:0] pipe [3];
  initial forever begin
    @(posedge clk);
    if (rst) begin
      armed = 1'b1;
      m_last = '0;
      m_run = 3;
      {m_err, m_cap, m_serr, m_dig} = '0;
      for (int i = 0; i < 4; i++) m_val[i] = '0;
      for (int i = 0; i < 3; i++) pipe[i] = '0;
    end else if (armed) begin
      m_fv = m_cap == 4'hF;
      if (m_fv) begin
        m_dig = {m_val[3], m_val[2], m_val[1], m_val[0]};
        m_serr = m_err;
        m_cap = '0;
      end
      m_run = ({an_in, seg_in} == m_last) ? m_run + 1 : 1;
      m_last = {an_in, seg_in};
      if (m_run == S && $onehot(~an_in)) begin
        logic [4:0] d;
        int sl;
        sl = 0;
        for (int i = 0; i < 4; i++) if (!an_in[i]) sl = i;
        d = mdec(seg_in);
        m_val[sl] = d[3:0];
        m_err[sl] = d[4];
        m_cap[sl] = 1'b1;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = {m_fv, m_dig, m_serr};
    end
  end
  initial forever begin
    @(negedge clk);
    if (frame_valid) fv_cnt++;
    if (armed) chk("model", {11'd0, frame_valid, digits, seg_err}, {11'd0, pipe[2]});
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an_in = a;
    seg_in = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct packed {logic [27:0] s; logic [15:0] dig; logic [3:0] err;} vec_t;
  vec_t tv [5];
  initial begin
    int f0;
    tv[0] = '{{P[4], P[3], P[2], P[1]}, 16'h4321, 4'b0000};
    tv[1] = '{{P[9], 7'b1111110, P[8], P[7]}, 16'h9F87, 4'b0100};
    tv[2] = '{{4{P[12]}}, HEX ? 16'hCCCC : 16'hFFFF, HEX ? 4'b0000 : 4'b1111};
    tv[3] = '{{P[8], P[6], P[5], P[0]}, 16'h8650, 4'b0000};
    tv[4] = '{{P[2], P[10], P[0], P[9]}, HEX ? 16'h2A09 : 16'h2F09, HEX ? 4'b0000 : 4'b0100};
    hold(4'hF, 7'h7F, 3);
    rst = 1'b0;
    chk("reset digits", digits, 16'h0);
    chk("reset seg_err", seg_err, 4'h0);
    chk("reset frame_valid", frame_valid, 1'b0);
    for (int v = 0; v < 5; v++) begin
      f0 = fv_cnt;
      for (int k = 0; k < 4; k++) hold(~(4'b1 << k), tv[v].s[k*7 +: 7], 8);
      hold(4'hF, 7'h7F, 6);
      chk($sformatf("vec%0d frames", v), fv_cnt - f0, 1);
      chk($sformatf("vec%0d digits", v), digits, tv[v].dig);
      chk($sformatf("vec%0d seg_err", v), seg_err, tv[v].err);
    end
    f0 = fv_cnt;
    hold(4'b1101, P[3], 8);
    hold(4'b1011, P[6], 8);
    hold(4'b0111, P[9], 8);
    hold(4'b1110, P[5], 3);
    hold(4'hF, 7'h7F, 8);
    chk("short hold no frame", fv_cnt - f0, 0);
    hold(4'b1110, P[5], 4);
    hold(4'hF, 7'h7F, 8);
    chk("stable hold frame", fv_cnt - f0, 1);
    chk("stable hold digits", digits, 16'h9635);
    f0 = fv_cnt;
    hold(4'b1110, P[1], 8);
    hold(4'b1101, P[5], 8);
    hold(4'b1011, P[2], 8);
    hold(4'b1101, P[6], 8);
    hold(4'b0111, P[7], 8);
    hold(4'hF, 7'h7F, 8);
    chk("overwrite frames", fv_cnt - f0, 1);
    chk("overwrite digits", digits, 16'h7261);
    f0 = fv_cnt;
    hold(4'b1110, P[1], 8);
    hold(4'b1101, P[2], 8);
    hold(4'b1011, P[3], 8);
    rst = 1'b1;
    hold(4'hF, 7'h7F, 2);
    rst = 1'b0;
    chk("midframe reset digits", digits, 16'h0);
    chk("midframe reset seg_err", seg_err, 4'h0);
    for (int k = 0; k < 3; k++) hold(~(4'b1 << k), P[0], 8);
    hold(4'hF, 7'h7F, 6);
    chk("post-reset partial frames", fv_cnt - f0, 0);
    hold(4'b0111, P[0], 8);
    hold(4'hF, 7'h7F, 6);
    chk("post-reset frames", fv_cnt - f0, 1);
    chk("post-reset digits", digits, 16'h0);
    chk("post-reset seg_err", seg_err, 4'h0);
    repeat (400) begin
      int r;
      logic [3:0] a;
      logic [6:0] s;
      r = $urandom_range(0, 9);
      a = r < 7 ? ~(4'b1 << $urandom_range(0, 3)) : r == 7 ? 4'hF : 4'($urandom);
      s = ($urandom_range(0, 2) == 0) ? 7'($urandom) : P[$urandom_range(0, 15)];
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        hold(a, s, $urandom_range(1, 2));
        rst = 1'b0;
      end
      hold(a, s, $urandom_range(1, 7));
    end
    hold(4'hF, 7'h7F, 10);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
